// File: rtl/lms_sched_if.sv
// Bundles the CtrlPort, the main/aux/core AXI-Stream links and the LMS core control
// signals of lms_sched.
interface lms_sched_if;
   logic        s_ctrlport_req_wr;
   logic        s_ctrlport_req_rd;
   logic [19:0] s_ctrlport_req_addr;
   logic [31:0] s_ctrlport_req_data;
   logic        s_ctrlport_resp_ack;
   logic [31:0] s_ctrlport_resp_data;

   logic [31:0] s_main_axis_tdata;
   logic        s_main_axis_tlast;
   logic        s_main_axis_tvalid;
   logic        s_main_axis_tready;

   logic [31:0] s_aux_axis_tdata;
   logic        s_aux_axis_tlast;
   logic        s_aux_axis_tvalid;
   logic        s_aux_axis_tready;

   logic [63:0] m_core_axis_tdata;
   logic        m_core_axis_tlast;
   logic        m_core_axis_tvalid;
   logic        m_core_axis_tready;

   logic        core_start;
   logic        core_clear;
   logic        core_idle;
   logic [15:0] core_mu;
   logic [5:0]  core_ntaps;

   modport slave (
      input  s_ctrlport_req_wr, s_ctrlport_req_rd, s_ctrlport_req_addr, s_ctrlport_req_data,
      output s_ctrlport_resp_ack, s_ctrlport_resp_data,
      input  s_main_axis_tdata, s_main_axis_tlast, s_main_axis_tvalid,
      output s_main_axis_tready,
      input  s_aux_axis_tdata, s_aux_axis_tlast, s_aux_axis_tvalid,
      output s_aux_axis_tready,
      output m_core_axis_tdata, m_core_axis_tlast, m_core_axis_tvalid,
      input  m_core_axis_tready,
      output core_start, core_clear, core_mu, core_ntaps,
      input  core_idle
   );

   modport master (
      output s_ctrlport_req_wr, s_ctrlport_req_rd, s_ctrlport_req_addr, s_ctrlport_req_data,
      input  s_ctrlport_resp_ack, s_ctrlport_resp_data,
      output s_main_axis_tdata, s_main_axis_tlast, s_main_axis_tvalid,
      input  s_main_axis_tready,
      output s_aux_axis_tdata, s_aux_axis_tlast, s_aux_axis_tvalid,
      input  s_aux_axis_tready,
      input  m_core_axis_tdata, m_core_axis_tlast, m_core_axis_tvalid,
      output m_core_axis_tready,
      input  core_start, core_clear, core_mu, core_ntaps,
      output core_idle
   );
endinterface

// File: rtl/lms_sched.sv
// Packet scheduler for the LMS core: pairs main/aux beats, sequences start/clear pulses,
// and exposes step size, tap count and statistics on CtrlPort.
module lms_sched #(
   parameter logic [19:0] ADDR_BASE    = 20'h0,
   parameter int          NUM_TAPS_MAX = 32,
   parameter logic [15:0] MU_RESET     = 16'h0100
) (
   input logic         ce_clk,
   input logic         ce_rst_n,
   lms_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_CLEAR       = 3'd1,
      ST_START       = 3'd2,
      ST_PAIR        = 3'd3,
      ST_RESYNC_MAIN = 3'd4,
      ST_RESYNC_AUX  = 3'd5,
      ST_DRAIN       = 3'd6
   } state_t;

   localparam logic [5:0]  NTAPS_MAX6  = 6'(NUM_TAPS_MAX);
   localparam logic [31:0] NTAPS_MAX32 = 32'(NUM_TAPS_MAX);

   state_t      state_q, state_d;
   logic        enable_q, enable_d;
   logic        clear_req_q, clear_req_d;
   logic [15:0] mu_q, mu_d;
   logic [5:0]  ntaps_q, ntaps_d;
   logic [15:0] core_mu_q, core_mu_d;
   logic [5:0]  core_ntaps_q, core_ntaps_d;
   logic [15:0] mismatch_q, mismatch_d;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic        pkt_active_q, pkt_active_d;
   logic        resp_ack_q, resp_ack_d;
   logic [31:0] resp_data_q, resp_data_d;

   logic        main_tready, aux_tready, core_tvalid, core_tlast;
   logic        core_start, core_clear;
   logic        in_window, req_wr, req_rd, beat;
   logic        mv, av, ml, al;
   logic [4:0]  offset;

   assign mv        = bus.s_main_axis_tvalid;
   assign av        = bus.s_aux_axis_tvalid;
   assign ml        = bus.s_main_axis_tlast;
   assign al        = bus.s_aux_axis_tlast;
   assign in_window = (bus.s_ctrlport_req_addr[19:5] == ADDR_BASE[19:5]);
   assign offset    = bus.s_ctrlport_req_addr[4:0];
   assign req_wr    = bus.s_ctrlport_req_wr & in_window;
   assign req_rd    = bus.s_ctrlport_req_rd & in_window;
   assign beat      = mv & av & bus.m_core_axis_tready;

   always_ff @(posedge ce_clk or negedge ce_rst_n) begin
      if (!ce_rst_n) begin
         state_q      <= ST_IDLE;
         enable_q     <= 1'b0;
         clear_req_q  <= 1'b0;
         mu_q         <= MU_RESET;
         ntaps_q      <= NTAPS_MAX6;
         core_mu_q    <= MU_RESET;
         core_ntaps_q <= NTAPS_MAX6;
         mismatch_q   <= '0;
         pkt_cnt_q    <= '0;
         pkt_active_q <= 1'b0;
         resp_ack_q   <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         clear_req_q  <= clear_req_d;
         mu_q         <= mu_d;
         ntaps_q      <= ntaps_d;
         core_mu_q    <= core_mu_d;
         core_ntaps_q <= core_ntaps_d;
         mismatch_q   <= mismatch_d;
         pkt_cnt_q    <= pkt_cnt_d;
         pkt_active_q <= pkt_active_d;
         resp_ack_q   <= resp_ack_d;
         resp_data_q  <= resp_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      enable_d     = enable_q;
      clear_req_d  = clear_req_q;
      mu_d         = mu_q;
      ntaps_d      = ntaps_q;
      core_mu_d    = core_mu_q;
      core_ntaps_d = core_ntaps_q;
      mismatch_d   = mismatch_q;
      pkt_cnt_d    = pkt_cnt_q;
      pkt_active_d = pkt_active_q;
      resp_ack_d   = req_wr | req_rd;
      resp_data_d  = '0;
      main_tready  = 1'b0;
      aux_tready   = 1'b0;
      core_tvalid  = 1'b0;
      core_tlast   = 1'b0;
      core_start   = 1'b0;
      core_clear   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_q && clear_req_q) begin
               state_d = ST_CLEAR;
            end else if (enable_q && mv && av) begin
               state_d = ST_START;
            end
         end
         ST_CLEAR: begin
            core_clear  = 1'b1;
            clear_req_d = 1'b0;
            state_d     = ST_DRAIN;
         end
         ST_START: begin
            core_start   = 1'b1;
            core_mu_d    = mu_q;
            core_ntaps_d = ntaps_q;
            pkt_active_d = 1'b1;
            state_d      = ST_PAIR;
         end
         ST_PAIR: begin
            main_tready = bus.m_core_axis_tready & av;
            aux_tready  = bus.m_core_axis_tready & mv;
            core_tvalid = mv & av;
            core_tlast  = ml | al;
            if (beat && (ml || al)) begin
               if (ml && al) begin
                  state_d = ST_DRAIN;
               end else begin
                  if (mismatch_q != 16'hFFFF) begin
                     mismatch_d = mismatch_q + 16'd1;
                  end
                  state_d = ml ? ST_RESYNC_AUX : ST_RESYNC_MAIN;
               end
            end
         end
         ST_RESYNC_MAIN: begin
            main_tready = 1'b1;
            if (mv && ml) begin
               state_d = ST_DRAIN;
            end
         end
         ST_RESYNC_AUX: begin
            aux_tready = 1'b1;
            if (av && al) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.core_idle) begin
               if (pkt_active_q) begin
                  pkt_cnt_d = pkt_cnt_q + 32'd1;
               end
               pkt_active_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Register writes come after the FSM so a software set of clear_req beats the hardware clear.
      if (req_wr) begin
         case (offset)
            5'h00: begin
               enable_d = bus.s_ctrlport_req_data[0];
               if (bus.s_ctrlport_req_data[1]) begin
                  clear_req_d = 1'b1;
               end
            end
            5'h04: mu_d = bus.s_ctrlport_req_data[15:0];
            5'h08: begin
               if (bus.s_ctrlport_req_data < 32'd2) begin
                  ntaps_d = 6'd2;
               end else if (bus.s_ctrlport_req_data > NTAPS_MAX32) begin
                  ntaps_d = NTAPS_MAX6;
               end else begin
                  ntaps_d = bus.s_ctrlport_req_data[5:0];
               end
            end
            default: ;
         endcase
      end

      if (req_rd) begin
         case (offset)
            5'h00:   resp_data_d = {30'd0, clear_req_q, enable_q};
            5'h04:   resp_data_d = {16'd0, mu_q};
            5'h08:   resp_data_d = {26'd0, ntaps_q};
            5'h0C:   resp_data_d = {mismatch_q, 13'd0, state_q};
            5'h10:   resp_data_d = pkt_cnt_q;
            default: resp_data_d = '0;
         endcase
      end
   end

   assign bus.s_main_axis_tready   = main_tready;
   assign bus.s_aux_axis_tready    = aux_tready;
   assign bus.m_core_axis_tdata    = {bus.s_aux_axis_tdata, bus.s_main_axis_tdata};
   assign bus.m_core_axis_tlast    = core_tlast;
   assign bus.m_core_axis_tvalid   = core_tvalid;
   assign bus.core_start           = core_start;
   assign bus.core_clear           = core_clear;
   assign bus.core_mu              = core_mu_q;
   assign bus.core_ntaps           = core_ntaps_q;
   assign bus.s_ctrlport_resp_ack  = resp_ack_q;
   assign bus.s_ctrlport_resp_data = resp_data_q;

endmodule

// File: tb/tb_lms_sched.sv
// Directed scoreboard bench for lms_sched: stimulus pushes expected beats and CtrlPort
// responses, a negedge monitor pops and compares them.
module tb_lms_sched;

   localparam logic [19:0] BASE      = 20'h00080;
   localparam logic [4:0]  OFF_CTRL  = 5'h00;
   localparam logic [4:0]  OFF_MU    = 5'h04;
   localparam logic [4:0]  OFF_NTAPS = 5'h08;
   localparam logic [4:0]  OFF_STAT  = 5'h0C;
   localparam logic [4:0]  OFF_PKT   = 5'h10;
   localparam int          LIMIT     = 20000;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      string       name;
   } resp_t;

   logic ce_clk;
   logic ce_rst_n;
   lms_sched_if bus ();

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cnt = 0;
   int clear_cnt = 0;
   int start_cyc = 0;
   int clear_cyc = 0;
   bit rand_ready = 0;
   bit abort = 0;

   logic [64:0] exp_q[$];
   resp_t       resp_q[$];
   logic        stalled_prev = 1'b0;
   logic [64:0] prev_beat = '0;

   lms_sched #(.ADDR_BASE(BASE), .NUM_TAPS_MAX(32), .MU_RESET(16'h0100)) dut (
      .ce_clk   (ce_clk),
      .ce_rst_n (ce_rst_n),
      .bus      (bus)
   );

   initial begin
      ce_clk = 1'b0;
      forever #5 ce_clk = ~ce_clk;
   end

   always @(posedge ce_clk) cyc <= cyc + 1;

   initial begin
      bus.m_core_axis_tready = 1'b1;
      forever begin
         @(posedge ce_clk);
         #1;
         bus.m_core_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge ce_clk) begin
      if (ce_rst_n) begin
         if (stalled_prev && bus.m_core_axis_tvalid) begin
            check("stall_hold", {bus.m_core_axis_tlast, bus.m_core_axis_tdata}, prev_beat);
         end
         if (bus.m_core_axis_tvalid && bus.m_core_axis_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got %h, expected none",
                        {bus.m_core_axis_tlast, bus.m_core_axis_tdata});
            end else begin
               check("beat", {bus.m_core_axis_tlast, bus.m_core_axis_tdata}, exp_q.pop_front());
            end
         end
         stalled_prev = bus.m_core_axis_tvalid && !bus.m_core_axis_tready;
         prev_beat    = {bus.m_core_axis_tlast, bus.m_core_axis_tdata};
         if (bus.s_ctrlport_resp_ack) begin
            if (resp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ack: got ack, expected none");
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               if (r.is_rd) check(r.name, bus.s_ctrlport_resp_data, r.data);
            end
         end
         if (bus.core_start) begin
            start_cnt++;
            start_cyc = cyc;
         end
         if (bus.core_clear) begin
            clear_cnt++;
            clear_cyc = cyc;
         end
      end else begin
         stalled_prev = 1'b0;
      end
   end

   task automatic ctrl_write(input logic [4:0] off, input logic [31:0] data);
      resp_t r;
      r.is_rd = 0;
      r.data  = '0;
      r.name  = "write";
      resp_q.push_back(r);
      bus.s_ctrlport_req_wr   = 1'b1;
      bus.s_ctrlport_req_addr = BASE + 20'(off);
      bus.s_ctrlport_req_data = data;
      @(posedge ce_clk);
      #1;
      bus.s_ctrlport_req_wr = 1'b0;
      @(posedge ce_clk);
      #1;
   endtask

   task automatic ctrl_read(input logic [4:0] off, input logic [31:0] exp, input string name);
      resp_t r;
      r.is_rd = 1;
      r.data  = exp;
      r.name  = name;
      resp_q.push_back(r);
      bus.s_ctrlport_req_rd   = 1'b1;
      bus.s_ctrlport_req_addr = BASE + 20'(off);
      @(posedge ce_clk);
      #1;
      bus.s_ctrlport_req_rd = 1'b0;
      @(posedge ce_clk);
      #1;
   endtask

   task automatic push_beats(input int n, input logic [31:0] mb, input logic [31:0] ab);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({(i == n - 1), ab + 32'(i), mb + 32'(i)});
      end
   endtask

   task automatic applyStimulus(input int nm, input int na, input logic [31:0] mb,
                                input logic [31:0] ab, input string name);
      int  im = 0;
      int  ia = 0;
      int  guard = 0;
      bit  fm, fa;
      while ((im < nm || ia < na) && !abort && guard < LIMIT) begin
         bus.s_main_axis_tvalid = (im < nm);
         bus.s_main_axis_tdata  = mb + 32'(im);
         bus.s_main_axis_tlast  = (im == nm - 1);
         bus.s_aux_axis_tvalid  = (ia < na);
         bus.s_aux_axis_tdata   = ab + 32'(ia);
         bus.s_aux_axis_tlast   = (ia == na - 1);
         @(negedge ce_clk);
         fm = bus.s_main_axis_tvalid && bus.s_main_axis_tready;
         fa = bus.s_aux_axis_tvalid && bus.s_aux_axis_tready;
         @(posedge ce_clk);
         #1;
         if (fm) im++;
         if (fa) ia++;
         guard++;
      end
      bus.s_main_axis_tvalid = 1'b0;
      bus.s_aux_axis_tvalid  = 1'b0;
      bus.s_main_axis_tlast  = 1'b0;
      bus.s_aux_axis_tlast   = 1'b0;
      check({name, "_done"}, 96'(guard < LIMIT), 96'd1);
   endtask

   task automatic checkOutput(input string name);
      check(name,
            {bus.s_main_axis_tready, bus.s_aux_axis_tready, bus.m_core_axis_tvalid,
             bus.m_core_axis_tlast, bus.core_start, bus.core_clear, bus.s_ctrlport_resp_ack,
             bus.s_ctrlport_resp_data, bus.core_mu, bus.core_ntaps},
            {7'd0, 32'd0, 16'h0100, 6'd32});
   endtask

   task automatic wait_start(input int s0, input string name);
      int g = 0;
      while (start_cnt == s0 && g < 200) begin
         @(posedge ce_clk);
         #1;
         g++;
      end
      check(name, 96'(g < 200), 96'd1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge ce_clk);
         #1;
      end
   endtask

   initial begin
      int s0, c0;
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0, c0;
      ce_rst_n                = 1'b0;
      bus.s_ctrlport_req_wr   = 1'b0;
      bus.s_ctrlport_req_rd   = 1'b0;
      bus.s_ctrlport_req_addr = '0;
      bus.s_ctrlport_req_data = '0;
      bus.s_main_axis_tvalid  = 1'b0;
      bus.s_main_axis_tdata   = '0;
      bus.s_main_axis_tlast   = 1'b0;
      bus.s_aux_axis_tvalid   = 1'b0;
      bus.s_aux_axis_tdata    = '0;
      bus.s_aux_axis_tlast    = 1'b0;
      bus.core_idle           = 1'b1;
      repeat (3) @(negedge ce_clk);
      checkOutput("reset_outputs");
      @(posedge ce_clk);
      #1;
      ce_rst_n = 1'b1;
      idle_cycles(1);
      ctrl_read(OFF_CTRL, 32'h0, "ctrl_reset");
      ctrl_read(OFF_STAT, 32'h0, "status_reset");
      ctrl_read(OFF_PKT, 32'h0, "pkt_reset");
      ctrl_read(OFF_NTAPS, 32'd32, "ntaps_reset");

      $display("[TB] aligned 8-beat packet");
      ctrl_write(OFF_CTRL, 32'h1);
      s0 = start_cnt;
      push_beats(8, 32'h0, 32'h100);
      applyStimulus(8, 8, 32'h0, 32'h100, "pkt8");
      idle_cycles(3);
      check("start_once", 96'(start_cnt - s0), 96'd1);
      ctrl_read(OFF_PKT, 32'd1, "pkt_cnt_1");
      ctrl_read(OFF_STAT, 32'h0, "status_after_pkt");

      $display("[TB] tap clipping and step-size shadowing");
      ctrl_write(OFF_NTAPS, 32'd0);
      ctrl_read(OFF_NTAPS, 32'd2, "ntaps_clip_low");
      ctrl_write(OFF_NTAPS, 32'd100);
      ctrl_read(OFF_NTAPS, 32'd32, "ntaps_clip_high");
      ctrl_write(OFF_NTAPS, 32'd16);
      ctrl_read(OFF_NTAPS, 32'd16, "ntaps_16");
      check("core_ntaps_shadow", 96'(bus.core_ntaps), 96'd32);
      s0 = start_cnt;
      push_beats(8, 32'h10, 32'h200);
      fork
         applyStimulus(8, 8, 32'h10, 32'h200, "pkt_mu");
         begin
            wait_start(s0, "mu_start_seen");
            ctrl_write(OFF_MU, 32'h0200);
            check("core_mu_midpkt", 96'(bus.core_mu), 96'h0100);
            check("core_ntaps_latched", 96'(bus.core_ntaps), 96'd16);
         end
      join
      idle_cycles(3);
      check("core_mu_after_pkt", 96'(bus.core_mu), 96'h0100);
      ctrl_read(OFF_MU, 32'h0200, "mu_readback");

      $display("[TB] main 4 beats vs aux 6 beats");
      push_beats(4, 32'h20, 32'h300);
      applyStimulus(4, 6, 32'h20, 32'h300, "pkt_mismatch");
      idle_cycles(3);
      check("core_mu_next_start", 96'(bus.core_mu), 96'h0200);
      ctrl_read(OFF_STAT, 32'h0001_0000, "status_mismatch");
      push_beats(3, 32'h40, 32'h400);
      applyStimulus(3, 3, 32'h40, 32'h400, "pkt_realigned");
      idle_cycles(3);
      ctrl_read(OFF_PKT, 32'd4, "pkt_cnt_4");

      $display("[TB] clear request while inputs valid");
      ctrl_write(OFF_CTRL, 32'h0);
      s0 = start_cnt;
      c0 = clear_cnt;
      push_beats(2, 32'h50, 32'h500);
      fork
         applyStimulus(2, 2, 32'h50, 32'h500, "pkt_clear");
         begin
            idle_cycles(3);
            ctrl_write(OFF_CTRL, 32'h3);
         end
      join
      idle_cycles(3);
      check("clear_once", 96'(clear_cnt - c0), 96'd1);
      check("start_after_clear_once", 96'(start_cnt - s0), 96'd1);
      check("clear_before_start", 96'(clear_cyc < start_cyc), 96'd1);
      ctrl_read(OFF_CTRL, 32'h1, "ctrl_after_clear");
      ctrl_read(OFF_PKT, 32'd5, "pkt_cnt_5");
      ctrl_write(OFF_STAT, 32'hFFFF_FFFF);
      ctrl_read(5'h14, 32'h0, "unmapped_read");

      $display("[TB] 1000 beats with random backpressure");
      rand_ready = 1;
      push_beats(1000, 32'h1000, 32'h2000);
      applyStimulus(1000, 1000, 32'h1000, 32'h2000, "pkt_random");
      rand_ready = 0;
      idle_cycles(4);
      ctrl_read(OFF_PKT, 32'd6, "pkt_cnt_6");
      ctrl_read(OFF_STAT, 32'h0001_0000, "status_after_random");

      $display("[TB] reset mid-packet");
      s0 = start_cnt;
      push_beats(20, 32'h7000, 32'h8000);
      fork
         applyStimulus(20, 20, 32'h7000, 32'h8000, "pkt_reset");
         begin
            wait_start(s0, "reset_start_seen");
            idle_cycles(3);
            ce_rst_n = 1'b0;
            abort    = 1;
            @(posedge ce_clk);
            #1;
            checkOutput("reset_midpkt_outputs");
         end
      join
      exp_q.delete();
      abort = 0;
      idle_cycles(1);
      ce_rst_n = 1'b1;
      idle_cycles(2);
      ctrl_read(OFF_STAT, 32'h0, "status_after_reset");
      ctrl_read(OFF_PKT, 32'h0, "pkt_after_reset");
      ctrl_read(OFF_CTRL, 32'h0, "ctrl_after_reset");
      idle_cycles(3);

      check("beat_queue_empty", 96'(exp_q.size()), 96'd0);
      check("resp_queue_empty", 96'(resp_q.size()), 96'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
